// File: rtl/board_render_ctrl_pkg.sv
// Shared board constants, types and tile palette for the board renderer.
package board_pkg;

   localparam int GRID_N  = 4;
   localparam int CELLS   = 16;
   localparam int EXP_W   = 4;
   localparam int EXP_MAX = 11;

   typedef logic [3:0]       cell_t;
   typedef logic [EXP_W-1:0] exp_t;

   typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_COPY} upd_state_t;

   function automatic logic [11:0] exp_to_color(input exp_t e);
      logic [11:0] c;
      case (e)
         4'd0:    c = 12'hBAA;
         4'd1:    c = 12'hEED;
         4'd2:    c = 12'hEDC;
         4'd3:    c = 12'hFB7;
         4'd4:    c = 12'hF96;
         4'd5:    c = 12'hF75;
         4'd6:    c = 12'hF53;
         4'd7:    c = 12'hEC7;
         4'd8:    c = 12'hEC6;
         4'd9:    c = 12'hEC5;
         4'd10:   c = 12'hEC3;
         4'd11:   c = 12'hEC2;
         default: c = 12'hF00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/board_render_ctrl_tile_locator.sv
// Combinational beam-to-cell locator: board hit, cell index and in-tile flag.
// With BOARD_OUTLINE_EN defined, also flags pixels within 2 px of a tile edge.
module tile_locator
   import board_pkg::*;
#(
   parameter int ORIGIN_X = 95,
   parameter int ORIGIN_Y = 15,
   parameter int TILE     = 100,
   parameter int GAP      = 10
) (
`ifdef BOARD_OUTLINE_EN
   output logic        o_edge,
`endif
   input  logic [9:0]  i_cx,
   input  logic [9:0]  i_cy,
   input  logic        i_video_on,
   output cell_t       o_cell,
   output logic        o_in_tile,
   output logic        o_board_hit
);

   localparam int PITCH = TILE + GAP;
   localparam logic signed [10:0] P1     = 11'(PITCH);
   localparam logic signed [10:0] P2     = 11'(2*PITCH);
   localparam logic signed [10:0] P3     = 11'(3*PITCH);
   localparam logic signed [10:0] SPAN   = 11'(4*PITCH - GAP);
   localparam logic signed [10:0] TILE_S = 11'(TILE);

   logic signed [10:0] w_dx, w_dy, w_ox, w_oy;
   logic [1:0]         w_col, w_row;

   assign w_dx = {1'b0, i_cx} - 11'(ORIGIN_X);
   assign w_dy = {1'b0, i_cy} - 11'(ORIGIN_Y);

   // Column/row by threshold compares, offset inside the pitch falls out alongside.
   always_comb begin
      w_col = 2'd0;
      w_ox  = w_dx;
      if (w_dx >= P3)      begin w_col = 2'd3; w_ox = w_dx - P3; end
      else if (w_dx >= P2) begin w_col = 2'd2; w_ox = w_dx - P2; end
      else if (w_dx >= P1) begin w_col = 2'd1; w_ox = w_dx - P1; end
   end

   always_comb begin
      w_row = 2'd0;
      w_oy  = w_dy;
      if (w_dy >= P3)      begin w_row = 2'd3; w_oy = w_dy - P3; end
      else if (w_dy >= P2) begin w_row = 2'd2; w_oy = w_dy - P2; end
      else if (w_dy >= P1) begin w_row = 2'd1; w_oy = w_dy - P1; end
   end

   assign o_cell      = {w_row, w_col};
   assign o_in_tile   = (w_ox < TILE_S) && (w_oy < TILE_S);
   assign o_board_hit = i_video_on && (w_dx >= 0) && (w_dx < SPAN)
                                   && (w_dy >= 0) && (w_dy < SPAN);

`ifdef BOARD_OUTLINE_EN
   assign o_edge = (w_ox < 11'sd2) || (w_ox >= TILE_S - 11'sd2)
                || (w_oy < 11'sd2) || (w_oy >= TILE_S - 11'sd2);
`endif

endmodule

// File: rtl/board_render_ctrl.sv
// Board renderer: 2-stage pixel pipeline over a double-buffered 4x4 tile store.
// Optional tile outlines via BOARD_OUTLINE_EN.
module board_render_ctrl
   import board_pkg::*;
#(
   parameter int          ORIGIN_X = 95,
   parameter int          ORIGIN_Y = 15,
   parameter int          TILE     = 100,
   parameter int          GAP      = 10,
   parameter logic [11:0] BG_COLOR = 12'hBAA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   input  logic [9:0] cx,
   input  logic [9:0] cy,
   input  logic       video_on,
   input  logic       frame_start,
   input  logic       upd_valid,
   output logic       upd_ready,
   input  logic [3:0] upd_cell,
   input  logic [3:0] upd_exp,
   input  logic       commit_req,
   output logic       commit_ack,
   output logic [3:0] VGA_R,
   output logic [3:0] VGA_G,
   output logic [3:0] VGA_B,
   output logic       draw
);

   upd_state_t  r_state;
   logic        r_ready, r_ack;
   exp_t        r_back  [CELLS];
   exp_t        r_front [CELLS];

   cell_t       w_cell, r_cell;
   logic        w_in_tile, r_in_tile, w_hit, r_hit, r_v1;
   logic [11:0] w_color, r_rgb;
   logic        r_draw;
   exp_t        w_exp;

`ifdef BOARD_OUTLINE_EN
   logic        w_edge, r_edge;
`endif

   tile_locator #(
      .ORIGIN_X(ORIGIN_X),
      .ORIGIN_Y(ORIGIN_Y),
      .TILE    (TILE),
      .GAP     (GAP)
   ) u_loc (
`ifdef BOARD_OUTLINE_EN
      .o_edge     (w_edge),
`endif
      .i_cx       (cx),
      .i_cy       (cy),
      .i_video_on (video_on),
      .o_cell     (w_cell),
      .o_in_tile  (w_in_tile),
      .o_board_hit(w_hit)
   );

   assign w_exp = r_front[r_cell];

   always_comb begin
      w_color = '0;
      if (r_hit) begin
         w_color = (r_in_tile && w_exp != '0) ? exp_to_color(w_exp) : BG_COLOR;
`ifdef BOARD_OUTLINE_EN
         if (r_in_tile && r_edge && w_exp != '0)
            w_color = '0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1      <= 1'b0;
         r_cell    <= '0;
         r_in_tile <= 1'b0;
         r_hit     <= 1'b0;
         r_rgb     <= '0;
         r_draw    <= 1'b0;
`ifdef BOARD_OUTLINE_EN
         r_edge    <= 1'b0;
`endif
      end else if (pix_en) begin
         r_v1      <= 1'b1;
         r_cell    <= w_cell;
         r_in_tile <= w_in_tile;
         r_hit     <= w_hit;
         r_rgb     <= r_v1 ? w_color : '0;
         r_draw    <= r_v1 & r_hit;
`ifdef BOARD_OUTLINE_EN
         r_edge    <= w_edge;
`endif
      end
   end

   // Front buffer is only ever loaded in COPY, which follows frame_start (blanking).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ready <= 1'b1;
         r_ack   <= 1'b0;
         for (int unsigned i = 0; i < CELLS; i++) begin
            r_back[i]  <= '0;
            r_front[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ack <= 1'b0;
               if (upd_valid && r_ready)
                  r_back[upd_cell] <= upd_exp;
               if (commit_req) begin
                  r_state <= ST_PENDING;
                  r_ready <= 1'b0;
               end
            end
            ST_PENDING: begin
               if (frame_start) begin
                  r_state <= ST_COPY;
                  r_ack   <= 1'b1;
               end
            end
            ST_COPY: begin
               r_front <= r_back;
               r_ack   <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_ack   <= 1'b0;
            end
         endcase
      end
   end

   assign upd_ready  = r_ready;
   assign commit_ack = r_ack;
   assign VGA_R      = r_rgb[11:8];
   assign VGA_G      = r_rgb[7:4];
   assign VGA_B      = r_rgb[3:0];
   assign draw       = r_draw;

endmodule

// File: tb/tb_board_render_ctrl.sv
// Randomized bench for board_render_ctrl against an arithmetic board model.
module tb_board_render_ctrl;

   localparam int          OX    = 95;
   localparam int          OY    = 15;
   localparam int          TILE  = 100;
   localparam int          PITCH = 110;
   localparam int          SPAN  = 430;
   localparam logic [11:0] BG    = 12'hBAA;

   logic       clk = 1'b0, rst = 1'b1, pix_en = 1'b0, video_on = 1'b0;
   logic [9:0] cx = '0, cy = '0;
   logic       frame_start = 1'b0, upd_valid = 1'b0, commit_req = 1'b0;
   logic [3:0] upd_cell = '0, upd_exp = '0;
   logic       upd_ready, commit_ack, draw;
   logic [3:0] VGA_R, VGA_G, VGA_B;

   int checks = 0, errors = 0;
   int front [16];
   int back  [16];
   bit pending = 0;
   logic [11:0] pal [16];

   board_render_ctrl dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .cx(cx), .cy(cy),
      .video_on(video_on), .frame_start(frame_start),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_cell(upd_cell), .upd_exp(upd_exp),
      .commit_req(commit_req), .commit_ack(commit_ack),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .draw(draw)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [12:0] model(input int x, input int y, input bit von);
      int dx = x - OX;
      int dy = y - OY;
      if (!von || dx < 0 || dy < 0 || dx >= SPAN || dy >= SPAN) return 13'h0;
      if ((dx % PITCH) >= TILE || (dy % PITCH) >= TILE) return {1'b1, BG};
      return {1'b1, pal[front[(dy / PITCH) * 4 + dx / PITCH]]};
   endfunction

   function automatic logic [12:0] outs();
      return {draw, VGA_R, VGA_G, VGA_B};
   endfunction

   task automatic pix_at(input string tag, input int x, input int y);
      @(negedge clk);
      cx = 10'(x); cy = 10'(y); video_on = (x < 640 && y < 480); pix_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 pix_en = 1'b0;
      check(tag, outs(), model(x, y, x < 640 && y < 480));
   endtask

   task automatic stream(input int n);
      logic [12:0] prev = '0;
      bit have = 0;
      int x, y;
      bit v;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if ($urandom % 5 == 0) begin
            x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
         end else begin
            x = $urandom_range(60, 560); y = $urandom_range(0, 500);
         end
         v = (x < 640) && (y < 480) && ($urandom % 8 != 0);
         cx = 10'(x); cy = 10'(y); video_on = v;
         pix_en = ($urandom % 4 != 0);
         @(posedge clk);
         #1;
         if (pix_en) begin
            if (have) check("stream", outs(), prev);
            prev = model(x, y, v);
            have = 1;
         end
      end
      @(negedge clk) pix_en = 1'b0;
   endtask

   task automatic wr(input int c, input int e, input bit cm);
      int n = 0;
      @(negedge clk);
      upd_valid = 1'b1; upd_cell = 4'(c); upd_exp = 4'(e); commit_req = cm;
      while (!upd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("wr_ready", upd_ready, 1);
      @(posedge clk);
      back[c] = e;
      if (cm) pending = 1;
      #1 upd_valid = 1'b0; commit_req = 1'b0;
   endtask

   task automatic commit();
      @(negedge clk) commit_req = 1'b1;
      @(posedge clk);
      pending = 1;
      #1 commit_req = 1'b0;
      check("ready_pend", upd_ready, 0);
   endtask

   task automatic fs();
      @(negedge clk) frame_start = 1'b1;
      @(posedge clk);
      #1 frame_start = 1'b0;
      if (pending) begin
         check("ack_hi", commit_ack, 1);
         check("ready_copy", upd_ready, 0);
         @(posedge clk);
         #1;
         check("ack_lo", commit_ack, 0);
         check("ready_back", upd_ready, 1);
         front = back;
         pending = 0;
      end else begin
         repeat (3) begin
            check("no_ack", commit_ack, 0);
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      pal[0] = BG;       pal[1] = 12'hEED;  pal[2] = 12'hEDC;  pal[3] = 12'hFB7;
      pal[4] = 12'hF96;  pal[5] = 12'hF75;  pal[6] = 12'hF53;  pal[7] = 12'hEC7;
      pal[8] = 12'hEC6;  pal[9] = 12'hEC5;  pal[10] = 12'hEC3; pal[11] = 12'hEC2;
      for (int i = 12; i < 16; i++) pal[i] = 12'hF00;
      for (int i = 0; i < 16; i++) begin front[i] = 0; back[i] = 0; end

      #23;
      check("rst_out", outs(), 0);
      check("rst_ready", upd_ready, 1);
      check("rst_ack", commit_ack, 0);
      @(negedge clk) rst = 1'b0;

      stream(400);
      pix_at("zero_tile", OX + 50, OY + 50);
      pix_at("zero_gap", OX + 105, OY + 50);

      // cell 5 exp 1
      wr(5, 1, 0);
      commit();
      fs();
      pix_at("c5_tile", OX + 110, OY + 110);
      pix_at("c5_gap", OX + 210, OY + 110);

      // commit held without frame_start; write on upd_valid must stall
      wr(0, 2, 1);
      stream(100);
      @(negedge clk) upd_valid = 1'b1; upd_cell = 4'd6; upd_exp = 4'd9;
      repeat (4) begin
         @(posedge clk);
         #1 check("stall_ready", upd_ready, 0);
      end
      @(negedge clk) upd_valid = 1'b0;
      @(negedge clk) commit_req = 1'b1;
      @(negedge clk) commit_req = 1'b0;
      pix_at("c0_before", OX + 50, OY + 50);
      fs();
      pix_at("c0_after", OX + 50, OY + 50);
      pix_at("c6_blocked", OX + 270, OY + 160);

      // frame_start while idle
      fs();

      // last write wins; out-of-range exponent
      wr(15, 3, 0);
      wr(15, 7, 0);
      wr(10, 13, 1);
      fs();
      pix_at("c15_last", OX + 380, OY + 380);
      pix_at("c10_err", OX + 270, OY + 270);
      pix_at("offscreen", 700, 200);
      stream(200);

      for (int r = 0; r < 4; r++) begin
         int nw = $urandom_range(1, 5);
         for (int k = 0; k < nw; k++)
            wr($urandom_range(0, 15), $urandom_range(0, 15), k == nw - 1);
         stream(60);
         fs();
         stream(200);
      end

      // reset while PENDING
      wr(5, 4, 1);
      pix_at("pre_rst", OX + 160, OY + 160);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_async_out", outs(), 0);
      check("rst_async_ready", upd_ready, 1);
      for (int i = 0; i < 16; i++) begin front[i] = 0; back[i] = 0; end
      pending = 0;
      @(negedge clk) rst = 1'b0;
      fs();
      pix_at("post_rst", OX + 160, OY + 160);
      stream(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/board_render_ctrl.md
Name: board_render_ctrl

Overview:
- Pixel-rate controller that renders the 4x4 game board of tiles on the VGA raster.
- For each pixel it finds which tile cell (if any) the beam is in, reads that cell's tile exponent from a double-buffered board store, and outputs a registered colour and draw flag.
- Game logic writes board updates into a back buffer. The controller commits them atomically at frame start, so no tearing is visible.
- Sits between the VGA timing generator and the VGA output mux.

Parameters:
- ORIGIN_X, 95, left pixel of the board.
- ORIGIN_Y, 15, top pixel of the board.
- TILE, 100, tile edge length in pixels.
- GAP, 10, spacing between tiles; pitch = TILE+GAP.
- BG_COLOR, 12'hBAA, colour of board gaps and of empty cells.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pix_en  in  1  pixel-rate enable; the pipeline advances only when high
- cx  in  10  current beam x
- cy  in  10  current beam y
- video_on  in  1  beam in visible area
- frame_start  in  1  single-clk pulse at start of vertical blanking
- upd_valid  in  1  board write request
- upd_ready  out  1  write accepted when upd_valid && upd_ready
- upd_cell  in  4  cell index = row*4+col
- upd_exp  in  4  tile exponent: 0 = empty, n = value 2^n, max 11
- commit_req  in  1  single-clk pulse: publish back buffer at next frame_start
- commit_ack  out  1  single-clk pulse when the copy completes
- VGA_R  out  4  registered red
- VGA_G  out  4  registered green
- VGA_B  out  4  registered blue
- draw  out  1  registered: pixel lies on the board area (tile or gap)

Behaviour:
- Reset (asynchronous): both buffers all 0; FSM in IDLE; upd_ready=1; commit_ack=0; VGA_R/G/B=0; draw=0; pipeline valid bits cleared.
- Pixel pipeline, advancing on pix_en only; latency 2 pix_en ticks from cx/cy to outputs.
  - S1: dx=cx-ORIGIN_X and dy=cy-ORIGIN_Y in 11-bit signed arithmetic.
    - board_hit = video_on, 0<=dx<4*pitch-GAP, same condition on dy.
    - col = number of thresholds {pitch, 2*pitch, 3*pitch} that are <=dx, found by compare (no divider); row likewise.
    - in_tile = (dx-col*pitch)<TILE && (dy-row*pitch)<TILE.
    - Register cell, in_tile and board_hit.
  - S2: exp = front[cell].
    - Colour = palette[exp] if in_tile, else BG_COLOR.
    - Register the colour into VGA_R/G/B and board_hit into draw.
    - If !board_hit, the colour is 0.
- Palette: fixed 16-entry ROM. Entry 0 = BG_COLOR; entries 1..11 are distinct tile colours; entries 12..15 = 12'hF00 (error red).
- Update FSM states: IDLE, PENDING, COPY.
  - IDLE: upd_ready=1; accepted writes go to back[upd_cell]. commit_req -> PENDING.
  - PENDING: upd_ready=0; writes are blocked. frame_start -> COPY.
  - COPY: lasts one clk. front <= back, all 16 entries in parallel. commit_ack=1 for that clk. Then -> IDLE.
- Boundary and corner cases:
  - commit_req and an accepted write in the same clk in IDLE: the write lands and is included in the commit.
  - commit_req while in PENDING or COPY: ignored.
  - frame_start while in IDLE: no effect.
  - Repeated writes to the same cell before commit: the last write wins.
  - The front buffer changes only in COPY, which happens during blanking, so a frame never mixes old and new boards.
  - Pixel coordinates beyond 639/479 give draw=0 through the video_on gating.
  - Reset mid-PENDING discards the pending commit and clears both buffers.

Optional Feature:
- Macro: BOARD_OUTLINE_EN.
- When defined: pixels within 2 px of any tile edge, inside a non-empty tile, output 12'h000 (outline). Implemented as an extra S1 compare, so latency is unchanged.
- When undefined: tiles are solid fills. Outputs are otherwise identical.

Decomposition:
- Shared package board_pkg holds:
  - board constants: GRID_N=4, CELLS=16, EXP_W=4, EXP_MAX=11;
  - the palette function exp_to_color;
  - the cell_t and exp_t typedefs.
- One natural sub-module: tile_locator, the S1 combinational cell/in_tile/board_hit calculation. The controller registers its outputs.

Test Plan:
- Reset, then sweep the full frame with a zero board -> every board pixel outputs BG_COLOR with draw=1; pixels outside the board output 0 with draw=0.
- Write cell 5 exp 1, commit, frame_start -> commit_ack pulses once. Pixel (ORIGIN_X+110, ORIGIN_Y+110) outputs palette[1] 2 pix_en ticks later. Pixel (ORIGIN_X+210, ORIGIN_Y+110), a gap, outputs BG_COLOR.
- Write cell 0 and then commit, with no frame_start -> the display is still unchanged; upd_ready=0 and a write held on upd_valid stalls. Pulse frame_start -> the update appears; upd_ready returns to 1 one clk after commit_ack.
- Write cell 15 exp 3, then exp 7, then commit -> the bottom-right tile shows palette[7]. Exp 13 written -> shows 12'hF00.
- Assert rst while in PENDING -> all outputs 0 immediately (asynchronously). A following frame_start gives no commit_ack.
- With BOARD_OUTLINE_EN defined and cell 0 non-empty -> pixel (ORIGIN_X+1, ORIGIN_Y+50) outputs 0x000 and pixel (ORIGIN_X+50, ORIGIN_Y+50) outputs the tile colour.
